alu_result_display: RTL and testbench

Time-multiplexed 8-digit seven-segment driver for the ALU result. It sits directly downstream of the ALU: it consumes the 32-bit `res` word and shows it as eight hex digits on the board's common-anode display. A scan counter refreshes one digit per slot. The input word is re-sampled only at frame boundaries, so a changing result never tears across digits.

---
 rtl/alu_result_display_if.sv | 17 +
 rtl/alu_result_display.sv | 108 ++++++++++
 tb/tb_alu_result_display.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_display_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_display_if
// Description : Bundle between the ALU and the seven-segment display driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_display_if;
    logic [31:0] res;
    logic        en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (output res, output en, input an, input seg, input dp);
    modport slave  (input res, input en, output an, output seg, output dp);
endinterface
`default_nettype wire

// File: rtl/alu_result_display.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_display
// Description : Eight-digit multiplexed hex display of the ALU result word.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_display #(
    parameter int DIV_CNT  = 100000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    alu_result_display_if.slave   bus
);

    localparam int             CW         = $clog2(DIV_CNT);
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(DIV_CNT - 1);

    logic [CW-1:0] cnt_q,  cnt_d;
    logic [2:0]    idx_q,  idx_d;
    logic [31:0]   snap_q, snap_d;
    logic [7:0]    an_q,   an_d;
    logic [6:0]    seg_q,  seg_d;
    logic          dp_q,   dp_d;

    logic          w_slot_end;
    logic          w_blank;
    logic [31:0]   w_upper;
    logic [3:0]    w_nib;

    // Anything outside 0..F (X/Z in simulation) falls to the blank pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            4'hF: hex_to_seg = 7'h0E;
            default: hex_to_seg = 7'h7F;
        endcase
    endfunction

    always_comb begin
        w_slot_end = (cnt_q == C_CNT_LAST);
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        snap_d     = snap_q;
        if (w_slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
            // Sampling only as digit 7 hands over to digit 0 keeps a frame tear-free.
            if (idx_q == 3'd7) begin
                snap_d = bus.res;
            end
        end
    end

    always_comb begin
        w_upper = snap_q >> {idx_q, 2'b00};
        w_nib   = snap_q[{idx_q, 2'b00} +: 4];
        w_blank = !bus.en || (LZ_BLANK && (idx_q != 3'd0) && (w_upper == 32'd0));
        an_d    = 8'hFF;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        if (w_blank) begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
        end else begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = hex_to_seg(w_nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            snap_q <= 32'd0;
            an_q   <= 8'hFF;
            seg_q  <= 7'h7F;
            dp_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_display
// Description : Scoreboard bench for alu_result_display (LZ on and off).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_display;

    localparam int DIV = 4;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] res = 32'd0;
    logic        en = 1'b1;

    int checks = 0;
    int errors = 0;
    bit xmode  = 1'b0;

    int          m_cnt  = 0;
    logic [2:0]  m_idx  = 3'd0;
    logic [31:0] m_snap = 32'd0;

    exp_t q_a[$];
    exp_t q_b[$];

    alu_result_display_if if_a ();
    alu_result_display_if if_b ();

    assign if_a.res = res;
    assign if_a.en  = en;
    assign if_b.res = res;
    assign if_b.en  = en;

    alu_result_display #(.DIV_CNT(DIV), .LZ_BLANK(1'b1)) u_lz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    alu_result_display #(.DIV_CNT(DIV), .LZ_BLANK(1'b0)) u_full (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] idx, input logic [31:0] snap,
                                   input logic en_v, input bit lz);
        exp_t e;
        int   i;
        bit   all_zero;
        i = int'(idx);
        all_zero = 1'b1;
        for (int j = i; j < 8; j++) begin
            if (snap[4*j +: 4] != 4'h0) all_zero = 1'b0;
        end
        e.dp = 1'b1;
        if (!en_v || (lz && i != 0 && all_zero)) begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
        end else begin
            e.an  = 8'hFF;
            e.an[i] = 1'b0;
            e.seg = SEG_TAB[snap[4*i +: 4]];
        end
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t got, input exp_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                   tag, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
        end
    endtask

    task automatic check_known(input string tag, input exp_t got);
        checks++;
        assert (!$isunknown(got)) else begin
            errors++;
            $error("FAIL %s: got an=%h seg=%h dp=%b, expected no X/Z",
                   tag, got.an, got.seg, got.dp);
        end
    endtask

    // One clock: push expected outputs, advance the model, pop and compare.
    task automatic step();
        exp_t ea, eb, ga, gb;
        q_a.push_back(model(m_idx, m_snap, en, 1'b1));
        q_b.push_back(model(m_idx, m_snap, en, 1'b0));
        if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            if (m_idx == 3'd7) m_snap = res;
            m_idx = m_idx + 3'd1;
        end else begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        ga = '{an: if_a.an, seg: if_a.seg, dp: if_a.dp};
        gb = '{an: if_b.an, seg: if_b.seg, dp: if_b.dp};
        if (xmode) begin
            check_known("xres_lz", ga);
            check_known("xres_full", gb);
        end else begin
            compare("scan_lz", ga, ea);
            compare("scan_full", gb, eb);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        exp_t blank, ga, gb;
        blank = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
        ga = '{an: if_a.an, seg: if_a.seg, dp: if_a.dp};
        gb = '{an: if_b.an, seg: if_b.seg, dp: if_b.dp};
        compare(tag, ga, blank);
        compare(tag, gb, blank);
    endtask

    initial begin
        exp_t first;
        // Reset asserted from time 0, checked mid-cycle while held low.
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        first = '{an: if_a.an, seg: if_a.seg, dp: if_a.dp};
        compare("first_edge", first, '{an: 8'hFE, seg: 7'h40, dp: 1'b1});

        // Leading-zero blanking.
        res = 32'h0000_0042;
        run(3 * 8 * DIV);

        // All digits active, then zero result (full instance shows eight 0s).
        res = 32'hFFFF_FFBE;
        run(2 * 8 * DIV);
        res = 32'h0000_0000;
        run(2 * 8 * DIV);

        // Tearing: change input while digit 3 is being scanned.
        res = 32'h1234_5678;
        run(2 * 8 * DIV);
        while (m_idx != 3'd3) step();
        res = 32'h8765_4321;
        run(2 * 8 * DIV);

        // Enable dropped during digit 5 for 6 cycles, with a capture pending.
        res = 32'h00AB_CDEF;
        while (m_idx != 3'd5) step();
        en = 1'b0;
        run(6);
        en = 1'b1;
        run(2 * 8 * DIV);

        // Reset mid-operation: outputs blank before any clock edge.
        run(5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        m_cnt  = 0;
        m_idx  = 3'd0;
        m_snap = 32'd0;
        @(negedge clk);
        check_reset_outputs("reset_mid_hold");
        rst_n = 1'b1;
        res   = 32'h0000_0ACE;
        run(2 * 8 * DIV + 4);

        // Undefined operand: outputs must remain fully defined.
        res   = 32'hxxxx_xxxx;
        xmode = 1'b1;
        run(2 * 8 * DIV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
